// File: rtl/vec3_pack.sv
// vec3_pack: gathers ARRAY_SIZE consecutive words from a first-word-fall-through
// scalar FIFO into one packed vector and pushes it into a downstream vector FIFO.
// Lane 0 holds the first word popped. A completed vector is always written;
// flush only discards a partially gathered vector.
module vec3_pack #(
    parameter int DATA_WIDTH = 32,
    parameter int ARRAY_SIZE = 3
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [DATA_WIDTH-1:0]                in_dout,
    input  logic                                 in_empty,
    output logic                                 in_rd_en,
    input  logic                                 flush,
    output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] out_din,
    output logic                                 out_wr_en,
    input  logic                                 out_full,
    output logic [31:0]                          vec_count
);

    localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_SIZE - 1);

    typedef enum logic {
        GATHER = 1'b0,
        PUSH   = 1'b1
    } state_t;

    state_t                                state_q, state_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] lane_q, lane_d;
    logic [31:0]                           cnt_q, cnt_d;

    // Next-state and handshake logic; both strobes are forced low while reset is asserted.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d   = state_q;
        idx_d     = idx_q;
        lane_d    = lane_q;
        cnt_d     = cnt_q;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;

        case (state_q)
            GATHER: begin
                in_rd_en = reset && !in_empty && !flush;
                if (flush) begin
                    // Drop the partial vector; stale lanes get overwritten by the next gather.
                    idx_d = '0;
                end else if (in_rd_en) begin
                    lane_d[idx_q] = in_dout;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = PUSH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PUSH: begin
                // Flush is ignored here: a completed vector is always written.
                out_wr_en = reset && !out_full;
                if (out_wr_en) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = GATHER;
                end
            end
            default: state_d = GATHER;
        endcase
    end

    // State, index, lane and counter registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            state_q <= GATHER;
            idx_q   <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_din   = lane_q;
    assign vec_count = cnt_q;

endmodule

// File: tb/tb_vec3_pack.sv
// tb_vec3_pack: directed scenario tests for vec3_pack (3 lanes x 32 bits).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_vec3_pack;

    localparam int DW = 32;
    localparam int AS = 3;

    logic                      clock;
    logic                      reset;
    logic [DW-1:0]             in_dout;
    logic                      in_empty;
    logic                      in_rd_en;
    logic                      flush;
    logic [AS-1:0][DW-1:0]     out_din;
    logic                      out_wr_en;
    logic                      out_full;
    logic [31:0]               vec_count;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_cnt = 32'd0;

    vec3_pack #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_dout   (in_dout),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .flush     (flush),
        .out_din   (out_din),
        .out_wr_en (out_wr_en),
        .out_full  (out_full),
        .vec_count (vec_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Present input values for the current cycle.
    task automatic drive(input logic empty, input logic [DW-1:0] dout, input logic fl, input logic full);
        in_empty = empty;
        in_dout  = dout;
        flush    = fl;
        out_full = full;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        repeat (2) next_cycle();
        @(negedge clock);
        checks++; if (in_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got %b want 0", in_rd_en); end
        checks++; if (out_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got %b want 0", out_wr_en); end
        checks++; if (vec_count !== 32'd0) begin failures++; $display("FAIL reset_vec_count got %0d want 0", vec_count); end
        checks++; if (out_din !== '0) begin failures++; $display("FAIL reset_out_din got %h want 0", out_din); end
        next_cycle();
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        next_cycle();
    endtask

    // Spec scenario 1: three words back-to-back, one write on the 4th cycle.
    task automatic test_back_to_back();
        logic [DW-1:0] w [3];
        logic [AS-1:0][DW-1:0] exp_vec;
        w[0] = 32'h0000_0400; w[1] = 32'h0000_0800; w[2] = 32'hFFFF_FC00;
        exp_vec = {w[2], w[1], w[0]};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, w[i], 1'b0, 1'b0);
            @(negedge clock);
            checks++; if (in_rd_en !== 1'b1) begin failures++; $display("FAIL b2b_rd_en[%0d] got %b want 1", i, in_rd_en); end
            checks++; if (out_wr_en !== 1'b0) begin failures++; $display("FAIL b2b_no_wr[%0d] got %b want 0", i, out_wr_en); end
            next_cycle();
        end
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        checks++; if (out_wr_en !== 1'b1) begin failures++; $display("FAIL b2b_wr got %b want 1", out_wr_en); end
        checks++; if (in_rd_en !== 1'b0) begin failures++; $display("FAIL b2b_push_rd got %b want 0", in_rd_en); end
        checks++; if (out_din !== exp_vec) begin failures++; $display("FAIL b2b_vec got %h want %h", out_din, exp_vec); end
        next_cycle();
        exp_cnt = exp_cnt + 32'd1;
        @(negedge clock);
        checks++; if (out_wr_en !== 1'b0) begin failures++; $display("FAIL b2b_single_pulse got %b want 0", out_wr_en); end
        checks++; if (vec_count !== exp_cnt) begin failures++; $display("FAIL b2b_vec_count got %0d want %0d", vec_count, exp_cnt); end
        checks++; if (out_din !== exp_vec) begin failures++; $display("FAIL b2b_hold got %h want %h", out_din, exp_vec); end
        next_cycle();
    endtask

    // Spec scenario 2: output full for 5 cycles in PUSH (flush also pulsed and ignored).
    task automatic test_full_stall();
        logic [AS-1:0][DW-1:0] exp_vec;
        exp_vec = {32'h33, 32'h22, 32'h11};
        drive(1'b0, 32'h11, 1'b0, 1'b1); next_cycle();
        drive(1'b0, 32'h22, 1'b0, 1'b1); next_cycle();
        drive(1'b0, 32'h33, 1'b0, 1'b1); next_cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h99, (i == 2), 1'b1);
            @(negedge clock);
            checks++; if (out_wr_en !== 1'b0) begin failures++; $display("FAIL stall_wr[%0d] got %b want 0", i, out_wr_en); end
            checks++; if (in_rd_en !== 1'b0) begin failures++; $display("FAIL stall_rd[%0d] got %b want 0", i, in_rd_en); end
            checks++; if (out_din !== exp_vec) begin failures++; $display("FAIL stall_vec[%0d] got %h want %h", i, out_din, exp_vec); end
            next_cycle();
        end
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        checks++; if (out_wr_en !== 1'b1) begin failures++; $display("FAIL stall_release_wr got %b want 1", out_wr_en); end
        checks++; if (out_din !== exp_vec) begin failures++; $display("FAIL stall_release_vec got %h want %h", out_din, exp_vec); end
        next_cycle();
        exp_cnt = exp_cnt + 32'd1;
        @(negedge clock);
        checks++; if (vec_count !== exp_cnt) begin failures++; $display("FAIL stall_vec_count got %0d want %0d", vec_count, exp_cnt); end
        checks++; if (out_wr_en !== 1'b0) begin failures++; $display("FAIL stall_after_wr got %b want 0", out_wr_en); end
        next_cycle();
    endtask

    // Spec scenario 3: two empty cycles between each word.
    task automatic test_gaps();
        logic [AS-1:0][DW-1:0] exp_vec;
        int wr_seen;
        exp_vec = {32'h3, 32'h2, 32'h1};
        wr_seen = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, DW'(i + 1), 1'b0, 1'b0);
            @(negedge clock);
            checks++; if (in_rd_en !== 1'b1) begin failures++; $display("FAIL gap_rd[%0d] got %b want 1", i, in_rd_en); end
            if (out_wr_en) wr_seen++;
            next_cycle();
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    drive(1'b1, 32'hBAD0_0000, 1'b0, 1'b0);
                    @(negedge clock);
                    checks++; if (in_rd_en !== 1'b0) begin failures++; $display("FAIL gap_empty_rd[%0d] got %b want 0", i, in_rd_en); end
                    if (out_wr_en) wr_seen++;
                    next_cycle();
                end
            end
        end
        checks++; if (wr_seen !== 0) begin failures++; $display("FAIL gap_spurious_wr got %0d want 0", wr_seen); end
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        checks++; if (out_wr_en !== 1'b1) begin failures++; $display("FAIL gap_wr got %b want 1", out_wr_en); end
        checks++; if (out_din !== exp_vec) begin failures++; $display("FAIL gap_vec got %h want %h", out_din, exp_vec); end
        next_cycle();
        exp_cnt = exp_cnt + 32'd1;
    endtask

    // Spec scenario 4: flush after two words discards the partial vector.
    task automatic test_flush();
        logic [AS-1:0][DW-1:0] exp_vec;
        int wr_seen;
        exp_vec = {32'hE, 32'hD, 32'hC};
        wr_seen = 0;
        drive(1'b0, 32'hA, 1'b0, 1'b0); next_cycle();
        drive(1'b0, 32'hB, 1'b0, 1'b0); next_cycle();
        drive(1'b0, 32'hFF, 1'b1, 1'b0);
        @(negedge clock);
        checks++; if (in_rd_en !== 1'b0) begin failures++; $display("FAIL flush_rd got %b want 0", in_rd_en); end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, DW'(32'hC + i), 1'b0, 1'b0);
            @(negedge clock);
            if (out_wr_en) wr_seen++;
            next_cycle();
        end
        checks++; if (wr_seen !== 0) begin failures++; $display("FAIL flush_spurious_wr got %0d want 0", wr_seen); end
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        checks++; if (out_wr_en !== 1'b1) begin failures++; $display("FAIL flush_wr got %b want 1", out_wr_en); end
        checks++; if (out_din !== exp_vec) begin failures++; $display("FAIL flush_vec got %h want %h", out_din, exp_vec); end
        next_cycle();
        exp_cnt = exp_cnt + 32'd1;
        @(negedge clock);
        checks++; if (vec_count !== exp_cnt) begin failures++; $display("FAIL flush_vec_count got %0d want %0d", vec_count, exp_cnt); end
        next_cycle();
    endtask

    // Spec scenario 5: asynchronous reset after two words, then a fresh vector.
    task automatic test_mid_reset();
        logic [AS-1:0][DW-1:0] exp_vec;
        int wr_seen;
        exp_vec = {32'h9, 32'h8, 32'h7};
        wr_seen = 0;
        drive(1'b0, 32'h55, 1'b0, 1'b0); next_cycle();
        drive(1'b0, 32'h66, 1'b0, 1'b0); next_cycle();
        drive(1'b0, 32'h77, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        exp_cnt = 32'd0;
        checks++; if (vec_count !== 32'd0) begin failures++; $display("FAIL mrst_vec_count got %0d want 0", vec_count); end
        checks++; if (out_din !== '0) begin failures++; $display("FAIL mrst_out_din got %h want 0", out_din); end
        checks++; if (in_rd_en !== 1'b0) begin failures++; $display("FAIL mrst_rd_en got %b want 0", in_rd_en); end
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, DW'(32'h7 + i), 1'b0, 1'b0);
            @(negedge clock);
            if (out_wr_en) wr_seen++;
            next_cycle();
        end
        checks++; if (wr_seen !== 0) begin failures++; $display("FAIL mrst_spurious_wr got %0d want 0", wr_seen); end
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        checks++; if (out_wr_en !== 1'b1) begin failures++; $display("FAIL mrst_wr got %b want 1", out_wr_en); end
        checks++; if (out_din !== exp_vec) begin failures++; $display("FAIL mrst_vec got %h want %h", out_din, exp_vec); end
        next_cycle();
        exp_cnt = exp_cnt + 32'd1;
        @(negedge clock);
        checks++; if (vec_count !== exp_cnt) begin failures++; $display("FAIL mrst_vec_count_after got %0d want %0d", vec_count, exp_cnt); end
        next_cycle();
    endtask

    // Continuous stream: one vector every ARRAY_SIZE+1 cycles, in arrival order.
    task automatic test_throughput();
        logic [AS-1:0][DW-1:0] exp_vec;
        logic [DW-1:0] word;
        int bad_rd, bad_wr, bad_vec;
        word = 32'h1000;
        bad_rd = 0; bad_wr = 0; bad_vec = 0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, word, 1'b0, 1'b0);
            @(negedge clock);
            if (in_rd_en !== ((c % 4) != 3)) bad_rd++;
            if (out_wr_en !== ((c % 4) == 3)) bad_wr++;
            if ((c % 4) == 3) begin
                exp_vec = {word - 32'd1, word - 32'd2, word - 32'd3};
                if (out_din !== exp_vec) bad_vec++;
            end
            if ((c % 4) != 3) word = word + 32'd1;
            next_cycle();
        end
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        exp_cnt = exp_cnt + 32'd5;
        checks++; if (bad_rd !== 0) begin failures++; $display("FAIL tput_rd_pattern got %0d bad cycles want 0", bad_rd); end
        checks++; if (bad_wr !== 0) begin failures++; $display("FAIL tput_wr_pattern got %0d bad cycles want 0", bad_wr); end
        checks++; if (bad_vec !== 0) begin failures++; $display("FAIL tput_vec_data got %0d bad vectors want 0", bad_vec); end
        @(negedge clock);
        checks++; if (vec_count !== exp_cnt) begin failures++; $display("FAIL tput_vec_count got %0d want %0d", vec_count, exp_cnt); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_full_stall();
        test_gaps();
        test_flush();
        test_mid_reset();
        test_throughput();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
